// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier controller, its
// iteration counter, the external datapath and the bench.
//   ITER_DEFAULT : default number of add/shift iterations (multiplier width)
//   ctrlState    : controller state encoding
//   cntWidth()   : width of the iteration index for a given iteration count
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int ITER_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } ctrlState;

    // A single-iteration build still needs a one-bit index so the port
    // never collapses to zero width.
    function automatic int cntWidth(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/iter_cnt.sv
// -----------------------------------------------------------------------------
// iter_cnt
// Iteration counter for the multiplier controller. Counts 0..ITER-1 and then
// saturates; it never wraps back to 0 on its own.
//   clk : clock, rising edge
//   clr : synchronous clear (also used by the controller to rearm the count)
//   inc : increment enable, ignored once the terminal count is reached
//   cnt : current iteration index
//   tc  : terminal count, high while cnt == ITER-1
// -----------------------------------------------------------------------------
module iter_cnt
    import mult_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT,
    parameter int W    = cntWidth(ITER)
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Terminal count is decoded straight from the register so the controller
    // can decide in the final SHIFT cycle whether to finish or loop again.
    assign tc = (cnt == W'(ITER - 1));

    // The count holds at ITER-1 instead of wrapping, so a stray increment
    // request in the last iteration can never push the index out of range.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
// Control unit for a sequential shift-and-add multiplier. The datapath
// (multiplier shift register, multiplicand register, accumulator) lives
// outside; this block only sequences it.
//   clk     : clock, rising edge
//   clr     : synchronous active-high reset
//   start   : multiply request, level sampled; four-phase handshake with done
//   q0      : LSB of the multiplier shift register
//   load    : parallel load of multiplier and multiplicand
//   acc_clr : clear of the accumulator / partial product
//   add     : accumulator add enable (q0 during a TEST cycle)
//   sft     : shift right of multiplier and accumulator
//   busy    : operation in progress (any state other than IDLE and DONE)
//   done    : product valid, held while start stays high
//   cnt     : current iteration index
// Sequence: IDLE -> LOAD -> (TEST -> SHIFT) x ITER -> DONE -> IDLE
// -----------------------------------------------------------------------------
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      q0,
    output logic                      load,
    output logic                      acc_clr,
    output logic                      add,
    output logic                      sft,
    output logic                      busy,
    output logic                      done,
    output logic [cntWidth(ITER)-1:0] cnt
);

    ctrlState state;
    logic     testPhase;
    logic     cntClr;
    logic     cntInc;
    logic     lastIter;

    // The index is rearmed to 0 whenever the controller is idle or about to
    // become idle, so it reads 0 in IDLE and in LOAD and only advances on
    // the SHIFT cycles of an operation.
    assign cntClr = clr || (state == IDLE) || ((state == DONE) && !start);
    assign cntInc = (state == SHIFT);

    iter_cnt #(
        .ITER (ITER),
        .W    (cntWidth(ITER))
    ) u_iter_cnt (
        .clk (clk),
        .clr (cntClr),
        .inc (cntInc),
        .cnt (cnt),
        .tc  (lastIter)
    );

    // add is the only output that is not purely registered: the multiplier
    // LSB is only known once the datapath has shifted, so it is gated by the
    // registered TEST flag in the same cycle.
    assign add = testPhase && q0;

    // State register and all registered outputs live in one block. Each
    // transition sets the strobes that belong to the state being entered, so
    // every output is a flop that matches the state it accompanies and the
    // strobes can never overlap. start is only looked at in IDLE and DONE,
    // which makes a request raised or dropped mid-operation harmless.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            load      <= 1'b0;
            acc_clr   <= 1'b0;
            testPhase <= 1'b0;
            sft       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        load    <= 1'b1;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= TEST;
                    load      <= 1'b0;
                    acc_clr   <= 1'b0;
                    testPhase <= 1'b1;
                end
                TEST: begin
                    state     <= SHIFT;
                    testPhase <= 1'b0;
                    sft       <= 1'b1;
                end
                SHIFT: begin
                    sft <= 1'b0;
                    if (lastIter) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= TEST;
                        testPhase <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    load      <= 1'b0;
                    acc_clr   <= 1'b0;
                    testPhase <= 1'b0;
                    sft       <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl
// Bench for mult_ctrl. A small model of the external multiplier shift register
// feeds q0. Every operation launched pushes its expected add pattern, shift
// count and latency onto a scoreboard; a negedge monitor pops and compares
// when done rises, and also checks strobe exclusivity and the iteration index
// every cycle.
// -----------------------------------------------------------------------------
module tb_mult_ctrl;
    import mult_pkg::*;

    localparam int ITER    = ITER_DEFAULT;
    localparam int CW      = cntWidth(ITER);
    localparam int LATENCY = 2 * ITER + 2;

    typedef struct {
        logic [ITER-1:0] addMask;
        int              sftPulses;
        int              latency;
    } expT;

    logic          clk;
    logic          clr;
    logic          start;
    logic          q0;
    logic          load;
    logic          acc_clr;
    logic          add;
    logic          sft;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    logic [ITER-1:0] multiplier;
    logic [ITER-1:0] mreg;

    expT             scoreboard[$];
    int              checkCount;
    int              errorCount;
    int              cycleCnt;
    int              startEdge;
    int              sftSeen;
    int              doneCycles;
    logic [ITER-1:0] addSeen;
    bit              prevDone;

    mult_ctrl #(
        .ITER (ITER)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .q0      (q0),
        .load    (load),
        .acc_clr (acc_clr),
        .add     (add),
        .sft     (sft),
        .busy    (busy),
        .done    (done),
        .cnt     (cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure latency from the edge after which start
    // was raised.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Stand-in for the external multiplier register: parallel load on load,
    // shift right on sft, LSB feeds the controller.
    always @(posedge clk) begin
        if (load) begin
            mreg <= multiplier;
        end else if (sft) begin
            mreg <= mreg >> 1;
        end
    end
    assign q0 = mreg[0];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Monitor: per-cycle exclusivity and index checks, and the scoreboard
    // comparison when an operation finishes.
    always @(negedge clk) begin
        expT expected;
        if (clr) begin
            sftSeen  = 0;
            addSeen  = '0;
            prevDone = 1'b0;
        end else begin
            checkOutput("strobeExcl",
                        32'($onehot0({add, sft, load}) && (acc_clr == load)), 32'd1);
            checkOutput("addOnlyBusy", 32'(add && !busy), 32'd0);
            if (load) begin
                sftSeen = 0;
                addSeen = '0;
            end
            if (busy) begin
                checkOutput("cntIndex", 32'(cnt), 32'(sftSeen));
            end
            if (add && sftSeen < ITER) begin
                addSeen[sftSeen] = 1'b1;
            end
            if (sft) begin
                sftSeen++;
            end
            if (done && !prevDone) begin
                checkOutput("sbNotEmpty", 32'(scoreboard.size() > 0), 32'd1);
                if (scoreboard.size() > 0) begin
                    expected = scoreboard.pop_front();
                    checkOutput("addPattern", 32'(addSeen), 32'(expected.addMask));
                    checkOutput("sftPulses", 32'(sftSeen), 32'(expected.sftPulses));
                    checkOutput("latency", 32'(cycleCnt - startEdge), 32'(expected.latency));
                end
                doneCycles = 0;
            end
            if (done) begin
                doneCycles++;
            end
            prevDone = done;
        end
    end

    // Waits at negedges for done, optionally toggling start at random while
    // the controller is busy (it must be ignored).
    task automatic waitDone(input bit jitter);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (jitter) start = 1'($urandom_range(0, 1));
                n++;
            end
        end
        checkOutput("doneSeen", 32'(seen), 32'd1);
    endtask

    // One complete operation: push the expectation, raise start, wait for
    // done, keep start high for 'hold' more cycles, then drop it and expect
    // IDLE one edge later.
    task automatic applyStimulus(input logic [ITER-1:0] m, input bit jitter,
                                 input int hold, input bit shortPulse);
        expT e;
        multiplier  = m;
        e.addMask   = m;
        e.sftPulses = ITER;
        e.latency   = LATENCY;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b1;
        startEdge = cycleCnt;
        @(posedge clk);
        #1;
        if (shortPulse) start = 1'b0;
        waitDone(jitter);
        start = (hold > 0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("doneHeld", 32'(done), 32'd1);
            checkOutput("cntHeld", 32'(cnt), 32'(ITER - 1));
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("backToIdle", 32'(dut.state), 32'(IDLE));
        checkOutput("doneLow", 32'(done), 32'd0);
        checkOutput("doneLength", 32'(doneCycles), 32'(hold + 1));
    endtask

    // All outputs must read zero right after a reset edge.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        checkOutput({tag, "_cnt"}, 32'(cnt), 32'd0);
        checkOutput({tag, "_strobes"}, 32'({load, acc_clr, add, sft}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  n;
        bit  found;
        expT dropped;
        checkCount = 0;
        errorCount = 0;
        cycleCnt   = 0;
        startEdge  = 0;
        sftSeen    = 0;
        doneCycles = 0;
        addSeen    = '0;
        prevDone   = 1'b0;
        multiplier = '0;
        clr        = 1'b1;
        start      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        clr = 1'b0;

        // Multiplier 1011: adds in iterations 0, 1 and 3; start held for 5
        // done cycles before being released.
        applyStimulus(ITER'(4'b1011), 1'b0, 4, 1'b0);

        // One-cycle start pulse: one operation, one done cycle, no re-run.
        applyStimulus(ITER'(4'b0110), 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noRetrigger", 32'(busy || load || done), 32'd0);
        end

        // Reset during the SHIFT of iteration 2, then a full clean run.
        multiplier          = ITER'(4'b0101);
        dropped.addMask     = multiplier;
        dropped.sftPulses   = ITER;
        dropped.latency     = LATENCY;
        scoreboard.push_back(dropped);
        @(posedge clk);
        #1;
        start     = 1'b1;
        startEdge = cycleCnt;
        n         = 0;
        found     = 1'b0;
        while (n < 40 && !found) begin
            @(negedge clk);
            if (sft && cnt == CW'(2)) found = 1'b1;
            else n++;
        end
        checkOutput("reachShift2", 32'(found), 32'd1);
        clr   = 1'b1;
        start = 1'b0;
        if (scoreboard.size() > 0) dropped = scoreboard.pop_back();
        @(posedge clk);
        #1;
        checkIdleOutputs("midReset");
        clr = 1'b0;
        applyStimulus(ITER'(4'b1101), 1'b0, 0, 1'b0);

        // clr and start on the same edge: clr wins.
        @(posedge clk);
        #1;
        clr   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clrWins_state", 32'(dut.state), 32'(IDLE));
        checkOutput("clrWins_load", 32'(load), 32'd0);
        clr   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clrWins_after", 32'(load || busy), 32'd0);

        // Random multipliers with start jittering during the operation.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(ITER'($urandom_range(0, (1 << ITER) - 1)), 1'b1,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        checkOutput("sbDrained", 32'(scoreboard.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    // Safety net in case the flow above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
